// File: rtl/lfsr_check_ctrl_pkg.sv
// Shared types and defaults for the LFSR pattern-check controller.
package lfsr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_UNLOCK_CNT = 8;

endpackage

// File: rtl/lfsr_check_ctrl_if.sv
// Control, stream and status signals of the LFSR pattern-check controller.
interface lfsr_check_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
);

    logic             start;
    logic             stop;
    logic [CNT_W-1:0] num_words;
    logic             dv_in;
    logic [WIDTH-1:0] datain;
    logic             busy;
    logic             locked;
    logic             done;
    logic             error;
    logic             lock_lost;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output start, stop, num_words, dv_in, datain,
        input  busy, locked, done, error, lock_lost, word_count, err_count
    );

    modport slave (
        input  start, stop, num_words, dv_in, datain,
        output busy, locked, done, error, lock_lost, word_count, err_count
    );

endinterface

// File: rtl/lfsr_check_ctrl_lfsr.sv
// Combinational one-step advance of the 32-bit Fibonacci LFSR
// x^32 + x^22 + x^2 + x + 1 (shift left, feedback into bit 0).
module lfsr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic feedback;

    assign feedback   = state[31] ^ state[21] ^ state[1] ^ state[0];
    assign next_state = {state[WIDTH-2:0], feedback};

endmodule

// File: rtl/lfsr_check_ctrl.sv
// Receive-side LFSR checker: acquires lock on a self-synchronised stream,
// counts checked words and mismatches, and drops lock on error bursts.
module lfsr_check_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT
) (
    input  logic               clk,
    input  logic               reset_n,
    lfsr_check_ctrl_if.slave   bus
);

    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned CE_W = $clog2(UNLOCK_CNT + 1);

    state_t           state;
    logic [WIDTH-1:0] pred;
    logic [WIDTH-1:0] pred_next;
    logic             have_prev;
    logic [MC_W-1:0]  match_cnt;
    logic [CE_W-1:0]  consec_err;

    logic             is_match;
    logic             lock_hit;
    logic             unlock_hit;
    logic             finish_hit;
    logic [CNT_W-1:0] word_count_inc;
    logic [CNT_W-1:0] err_count_inc;

    lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .state      (bus.datain),
        .next_state (pred_next)
    );

    assign is_match       = have_prev && (bus.datain == pred);
    assign lock_hit       = is_match && (match_cnt == MC_W'(LOCK_CNT - 1));
    assign unlock_hit     = !is_match && (consec_err == CE_W'(UNLOCK_CNT - 1));
    assign word_count_inc = (&bus.word_count) ? bus.word_count : bus.word_count + CNT_W'(1);
    assign err_count_inc  = (&bus.err_count) ? bus.err_count : bus.err_count + CNT_W'(1);
    assign finish_hit     = (bus.num_words != '0) && (word_count_inc == bus.num_words);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pred           <= '0;
            have_prev      <= 1'b0;
            match_cnt      <= '0;
            consec_err     <= '0;
            bus.busy       <= 1'b0;
            bus.locked     <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.lock_lost  <= 1'b0;
            bus.word_count <= '0;
            bus.err_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= ACQUIRE;
                        have_prev      <= 1'b0;
                        match_cnt      <= '0;
                        consec_err     <= '0;
                        bus.busy       <= 1'b1;
                        bus.locked     <= 1'b0;
                        bus.done       <= 1'b0;
                        bus.error      <= 1'b0;
                        bus.lock_lost  <= 1'b0;
                        bus.word_count <= '0;
                        bus.err_count  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (bus.dv_in) begin
                        pred      <= pred_next;
                        have_prev <= 1'b1;
                        match_cnt <= is_match ? match_cnt + MC_W'(1) : '0;
                        if (lock_hit) begin
                            state      <= RUN;
                            consec_err <= '0;
                            bus.locked <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.dv_in) begin
                        pred           <= pred_next;
                        bus.word_count <= word_count_inc;
                        if (is_match) begin
                            consec_err <= '0;
                        end else begin
                            consec_err    <= consec_err + CE_W'(1);
                            bus.err_count <= err_count_inc;
                            bus.error     <= 1'b1;
                        end
                        // Reaching the word budget wins over an unlock on the same word.
                        if (finish_hit) begin
                            state      <= DONE;
                            bus.busy   <= 1'b0;
                            bus.locked <= 1'b0;
                            bus.done   <= 1'b1;
                        end else if (unlock_hit) begin
                            state         <= ACQUIRE;
                            match_cnt     <= '0;
                            bus.locked    <= 1'b0;
                            bus.lock_lost <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A word arriving with stop is still processed above; stop then overrides the state.
            if (bus.stop && (state == ACQUIRE || state == RUN)) begin
                state      <= DONE;
                bus.busy   <= 1'b0;
                bus.locked <= 1'b0;
                bus.done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_check_ctrl.sv
// Directed-vector bench for lfsr_check_ctrl with hand-derived expectations.
module tb_lfsr_check_ctrl;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    logic [31:0] cur;

    lfsr_check_ctrl_if #(.WIDTH(32), .CNT_W(32)) bus ();

    lfsr_check_ctrl #(
        .WIDTH      (32),
        .CNT_W      (32),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] nxt(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic send(input logic [31:0] w);
        bus.dv_in  = 1'b1;
        bus.datain = w;
        @(negedge clk);
        bus.dv_in  = 1'b0;
    endtask

    task automatic send_good(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            send(cur);
            cur = nxt(cur);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.num_words = '0;
        bus.dv_in     = 1'b0;
        bus.datain    = '0;
        repeat (2) @(negedge clk);
        vectors++; if ({bus.busy, bus.locked, bus.done, bus.error, bus.lock_lost} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b exp 00000", {bus.busy, bus.locked, bus.done, bus.error, bus.lock_lost}); end
        vectors++; if (bus.word_count !== 32'd0 || bus.err_count !== 32'd0) begin miscompares++; $display("FAIL reset_counts got wc=%0d ec=%0d exp 0/0", bus.word_count, bus.err_count); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_lock();
        cur = 32'h0000_0001;
        pulse_start();
        vectors++; if (bus.busy !== 1'b1 || bus.locked !== 1'b0) begin miscompares++; $display("FAIL start_busy got busy=%b locked=%b exp 1/0", bus.busy, bus.locked); end
        send_good(4);
        vectors++; if (bus.locked !== 1'b0 || bus.word_count !== 32'd0) begin miscompares++; $display("FAIL acq_4words got locked=%b wc=%0d exp 0/0", bus.locked, bus.word_count); end
        send_good(1);
        vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL lock_5th got %b exp 1", bus.locked); end
        send_good(100);
        vectors++; if (bus.word_count !== 32'd100) begin miscompares++; $display("FAIL clean_wc got %0d exp 100", bus.word_count); end
        vectors++; if (bus.err_count !== 32'd0 || bus.error !== 1'b0) begin miscompares++; $display("FAIL clean_err got ec=%0d err=%b exp 0/0", bus.err_count, bus.error); end
    endtask

    task automatic test_bit_flip();
        send_good(9);
        send(cur ^ 32'h0000_0001);
        cur = nxt(cur);
        vectors++; if (bus.err_count !== 32'd1) begin miscompares++; $display("FAIL flip_first got %0d exp 1", bus.err_count); end
        send_good(1);
        vectors++; if (bus.err_count !== 32'd2) begin miscompares++; $display("FAIL flip_second got %0d exp 2", bus.err_count); end
        send_good(4);
        vectors++; if (bus.err_count !== 32'd2 || bus.word_count !== 32'd115) begin miscompares++; $display("FAIL flip_counts got ec=%0d wc=%0d exp 2/115", bus.err_count, bus.word_count); end
        vectors++; if ({bus.error, bus.locked, bus.lock_lost} !== 3'b110) begin miscompares++; $display("FAIL flip_flags got %b exp 110", {bus.error, bus.locked, bus.lock_lost}); end
    endtask

    task automatic test_lock_loss();
        logic [31:0] junk [8];
        junk = '{32'hA5A5_A5A5, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_F0F0,
                 32'hCAFE_BABE, 32'h8000_0001, 32'h5555_AAAA, 32'h0BAD_F00D};
        pulse_stop();
        pulse_start();
        send_good(5);
        vectors++; if (bus.locked !== 1'b1 || bus.word_count !== 32'd0) begin miscompares++; $display("FAIL relock_fresh got locked=%b wc=%0d exp 1/0", bus.locked, bus.word_count); end
        for (int i = 0; i < 7; i++) send(junk[i]);
        vectors++; if (bus.locked !== 1'b1 || bus.err_count !== 32'd7) begin miscompares++; $display("FAIL junk7 got locked=%b ec=%0d exp 1/7", bus.locked, bus.err_count); end
        send(junk[7]);
        vectors++; if ({bus.locked, bus.lock_lost, bus.busy} !== 3'b011 || bus.err_count !== 32'd8) begin miscompares++; $display("FAIL junk8 got lk/ll/busy=%b ec=%0d exp 011/8", {bus.locked, bus.lock_lost, bus.busy}, bus.err_count); end
        // First clean word only resynchronises the predictor; four matches follow it.
        send_good(4);
        vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL reacq_4 got %b exp 0", bus.locked); end
        send_good(1);
        vectors++; if (bus.locked !== 1'b1 || bus.err_count !== 32'd8 || bus.word_count !== 32'd8) begin miscompares++; $display("FAIL reacq_5 got locked=%b ec=%0d wc=%0d exp 1/8/8", bus.locked, bus.err_count, bus.word_count); end
        send_good(2);
        vectors++; if (bus.word_count !== 32'd10 || bus.err_count !== 32'd8 || bus.lock_lost !== 1'b1) begin miscompares++; $display("FAIL after_relock got wc=%0d ec=%0d ll=%b exp 10/8/1", bus.word_count, bus.err_count, bus.lock_lost); end
    endtask

    task automatic test_bounded();
        pulse_stop();
        bus.num_words = 32'd16;
        pulse_start();
        send_good(5);
        send_good(15);
        vectors++; if (bus.word_count !== 32'd15 || bus.done !== 1'b0) begin miscompares++; $display("FAIL bound_15 got wc=%0d done=%b exp 15/0", bus.word_count, bus.done); end
        send_good(1);
        vectors++; if (bus.word_count !== 32'd16 || {bus.done, bus.busy, bus.locked} !== 3'b100) begin miscompares++; $display("FAIL bound_16 got wc=%0d d/b/l=%b exp 16/100", bus.word_count, {bus.done, bus.busy, bus.locked}); end
        send_good(3);
        vectors++; if (bus.word_count !== 32'd16 || bus.err_count !== 32'd0 || bus.done !== 1'b1) begin miscompares++; $display("FAIL bound_frozen got wc=%0d ec=%0d done=%b exp 16/0/1", bus.word_count, bus.err_count, bus.done); end
    endtask

    task automatic test_stop_vs_data();
        bus.num_words = '0;
        pulse_start();
        vectors++; if (bus.word_count !== 32'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL restart_clear got wc=%0d busy=%b done=%b exp 0/1/0", bus.word_count, bus.busy, bus.done); end
        send_good(5);
        send_good(3);
        pulse_start();
        vectors++; if (bus.locked !== 1'b1 || bus.word_count !== 32'd3) begin miscompares++; $display("FAIL start_busy_ign got locked=%b wc=%0d exp 1/3", bus.locked, bus.word_count); end
        bus.stop   = 1'b1;
        bus.dv_in  = 1'b1;
        bus.datain = cur ^ 32'h8000_0000;
        cur = nxt(cur);
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.dv_in = 1'b0;
        vectors++; if (bus.word_count !== 32'd4 || bus.err_count !== 32'd1 || bus.error !== 1'b1) begin miscompares++; $display("FAIL stop_data got wc=%0d ec=%0d err=%b exp 4/1/1", bus.word_count, bus.err_count, bus.error); end
        vectors++; if ({bus.done, bus.busy, bus.locked} !== 3'b100) begin miscompares++; $display("FAIL stop_state got d/b/l=%b exp 100", {bus.done, bus.busy, bus.locked}); end
        pulse_stop();
        send_good(2);
        vectors++; if (bus.word_count !== 32'd4 || bus.done !== 1'b1) begin miscompares++; $display("FAIL done_frozen got wc=%0d done=%b exp 4/1", bus.word_count, bus.done); end
        pulse_start();
        vectors++; if (bus.word_count !== 32'd0 || bus.err_count !== 32'd0 || {bus.busy, bus.done, bus.error} !== 3'b100) begin miscompares++; $display("FAIL done_restart got wc=%0d ec=%0d b/d/e=%b exp 0/0/100", bus.word_count, bus.err_count, {bus.busy, bus.done, bus.error}); end
    endtask

    task automatic test_async_reset();
        send_good(5);
        send_good(1);
        send(cur ^ 32'h0001_0000);
        cur = nxt(cur);
        send_good(1);
        vectors++; if (bus.err_count !== 32'd2 || bus.word_count !== 32'd3 || bus.locked !== 1'b1) begin miscompares++; $display("FAIL pre_reset got ec=%0d wc=%0d locked=%b exp 2/3/1", bus.err_count, bus.word_count, bus.locked); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if ({bus.busy, bus.locked, bus.done, bus.error, bus.lock_lost} !== 5'b0 || bus.word_count !== 32'd0 || bus.err_count !== 32'd0) begin miscompares++; $display("FAIL async_reset got flags=%b wc=%0d ec=%0d exp 00000/0/0", {bus.busy, bus.locked, bus.done, bus.error, bus.lock_lost}, bus.word_count, bus.err_count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_good(6);
        vectors++; if (bus.busy !== 1'b0 || bus.locked !== 1'b0 || bus.word_count !== 32'd0) begin miscompares++; $display("FAIL post_reset_idle got busy=%b locked=%b wc=%0d exp 0/0/0", bus.busy, bus.locked, bus.word_count); end
        pulse_start();
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL post_reset_start got %b exp 1", bus.busy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur         = 32'h0000_0001;
        test_reset();
        test_clean_lock();
        test_bit_flip();
        test_lock_loss();
        test_bounded();
        test_stop_vs_data();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
